// File: rtl/simd_agg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_agg_pkg
// Description : Opcodes, core state encoding and lane arithmetic helpers
//               shared by the SIMD aggregation array.
// Revision    : 1.0 - initial release
// ============================================================================
package simd_agg_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MAX = 1'b1;

    // Lane arithmetic is done at this width; ACC_W must stay below it.
    localparam int MATH_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } core_state_t;

    function automatic logic signed [MATH_W-1:0] sext(input logic [MATH_W-1:0] x,
                                                      input int w);
        logic [MATH_W-1:0] sh;
        sh = x << (MATH_W - w);
        return $signed(sh) >>> (MATH_W - w);
    endfunction

    function automatic logic signed [MATH_W-1:0] sat_add(input logic signed [MATH_W-1:0] a,
                                                         input logic signed [MATH_W-1:0] b,
                                                         input int w);
        logic signed [MATH_W-1:0] s;
        logic signed [MATH_W-1:0] hi;
        logic signed [MATH_W-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_agg_array_if.sv
`default_nettype none
// ============================================================================
// Module      : simd_agg_array_if
// Description : Feature-beat input and result write-back bus of the array.
// Revision    : 1.0 - initial release
// ============================================================================
interface simd_agg_array_if #(
    parameter int SIMD_NUM = 64,
    parameter int LANE_NUM = 32,
    parameter int FEAT_W   = 8,
    parameter int ACC_W    = 16,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 8
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [SIMD_NUM-1:0]                  in_en;
    logic [SIMD_NUM-1:0]                  in_op;
    logic [SIMD_NUM-1:0]                  in_tag;
    logic [SIMD_NUM*ADDR_W-1:0]           in_addr;
    logic [SIMD_NUM*LANE_NUM*FEAT_W-1:0]  in_data;
    logic [SIMD_NUM-1:0]                  out_valid;
    logic                                 out_ready;
    logic [SIMD_NUM*ADDR_W-1:0]           out_addr;
    logic [SIMD_NUM*LANE_NUM*ACC_W-1:0]   out_data;
    logic [SIMD_NUM*CNT_W-1:0]            out_cnt;
    logic [SIMD_NUM-1:0]                  busy;
    logic [SIMD_NUM-1:0]                  err_op;

    modport master (
        output in_valid, in_en, in_op, in_tag, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_cnt, busy, err_op
    );

    modport slave (
        input  in_valid, in_en, in_op, in_tag, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_cnt, busy, err_op
    );
endinterface
`default_nettype wire

// File: rtl/simd_agg_core.sv
`default_nettype none
// ============================================================================
// Module      : simd_agg_core
// Description : One aggregation core: LANE_NUM add/max accumulators, element
//               counter, op/address latch and IDLE/ACC/DONE sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_agg_core
    import simd_agg_pkg::*;
#(
    parameter int LANE_NUM = 32,
    parameter int FEAT_W   = 8,
    parameter int ACC_W    = 16,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 8
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         accept,
    input  wire logic                         en,
    input  wire logic                         op,
    input  wire logic                         tag,
    input  wire logic [ADDR_W-1:0]            addr,
    input  wire logic [LANE_NUM*FEAT_W-1:0]   data,
    input  wire logic                         drain,
    output logic                              done,
    output logic                              busy,
    output logic                              err_op,
    output logic [ADDR_W-1:0]                 out_addr,
    output logic [LANE_NUM*ACC_W-1:0]         out_data,
    output logic [CNT_W-1:0]                  out_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    core_state_t         r_state;
    logic                r_op;
    logic                r_done;
    logic                r_busy;
    logic                r_err_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc  [LANE_NUM];
    logic [ACC_W-1:0]    w_load [LANE_NUM];
    logic [ACC_W-1:0]    w_next [LANE_NUM];
    logic                w_take;

    assign w_take = accept & en;

    for (genvar j = 0; j < LANE_NUM; j++) begin : g_lane
        logic signed [MATH_W-1:0] w_in;
        logic signed [MATH_W-1:0] w_cur;
        logic signed [MATH_W-1:0] w_sum;
        logic signed [MATH_W-1:0] w_max;

        assign w_in   = sext(MATH_W'(data[j*FEAT_W +: FEAT_W]), FEAT_W);
        assign w_cur  = sext(MATH_W'(r_acc[j]), ACC_W);
        assign w_sum  = sat_add(w_cur, w_in, ACC_W);
        assign w_max  = (w_in > w_cur) ? w_in : w_cur;
        assign w_load[j] = w_in[ACC_W-1:0];
        assign w_next[j] = (r_op == OP_MAX) ? w_max[ACC_W-1:0] : w_sum[ACC_W-1:0];
        assign out_data[j*ACC_W +: ACC_W] = r_acc[j];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_op     <= OP_ADD;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err_op <= 1'b0;
            r_addr   <= '0;
            r_cnt    <= '0;
            for (int j = 0; j < LANE_NUM; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        for (int j = 0; j < LANE_NUM; j++) begin
                            r_acc[j] <= w_load[j];
                        end
                        r_op   <= op;
                        r_addr <= addr;
                        r_cnt  <= CNT_W'(1);
                        r_busy <= 1'b1;
                        r_done <= tag;
                        r_state <= tag ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (w_take) begin
                        for (int j = 0; j < LANE_NUM; j++) begin
                            r_acc[j] <= w_next[j];
                        end
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        // A conflicting opcode is flagged but the latched one wins.
                        if (op != r_op) begin
                            r_err_op <= 1'b1;
                        end
                        if (tag) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (drain) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign done     = r_done;
    assign busy     = r_busy;
    assign err_op   = r_err_op;
    assign out_addr = r_addr;
    assign out_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/simd_agg_array.sv
`default_nettype none
// ============================================================================
// Module      : simd_agg_array
// Description : SIMD_NUM independent aggregation cores sharing one beat
//               handshake; any undrained result stalls the whole array.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_agg_array
    import simd_agg_pkg::*;
#(
    parameter int SIMD_NUM = 64,
    parameter int LANE_NUM = 32,
    parameter int FEAT_W   = 8,
    parameter int ACC_W    = 16,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    simd_agg_array_if.slave    bus
);

    localparam int DIN_W  = LANE_NUM * FEAT_W;
    localparam int DOUT_W = LANE_NUM * ACC_W;

    logic [SIMD_NUM-1:0] w_done;
    logic                w_accept;

    assign bus.in_ready  = ~|w_done;
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = w_done;

    for (genvar i = 0; i < SIMD_NUM; i++) begin : g_core
        simd_agg_core #(
            .LANE_NUM (LANE_NUM),
            .FEAT_W   (FEAT_W),
            .ACC_W    (ACC_W),
            .ADDR_W   (ADDR_W),
            .CNT_W    (CNT_W)
        ) u_core (
            .clk      (clk),
            .rst      (rst),
            .accept   (w_accept),
            .en       (bus.in_en[i]),
            .op       (bus.in_op[i]),
            .tag      (bus.in_tag[i]),
            .addr     (bus.in_addr[i*ADDR_W +: ADDR_W]),
            .data     (bus.in_data[i*DIN_W +: DIN_W]),
            .drain    (bus.out_ready),
            .done     (w_done[i]),
            .busy     (bus.busy[i]),
            .err_op   (bus.err_op[i]),
            .out_addr (bus.out_addr[i*ADDR_W +: ADDR_W]),
            .out_data (bus.out_data[i*DOUT_W +: DOUT_W]),
            .out_cnt  (bus.out_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_agg_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_agg_array
// Description : Directed self-checking bench for a 3-core, 2-lane array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_agg_array;

    localparam int SIMD_NUM = 3;
    localparam int LANE_NUM = 2;
    localparam int FEAT_W   = 8;
    localparam int ACC_W    = 16;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    simd_agg_array_if #(
        .SIMD_NUM(SIMD_NUM), .LANE_NUM(LANE_NUM), .FEAT_W(FEAT_W),
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) bus ();

    simd_agg_array #(
        .SIMD_NUM(SIMD_NUM), .LANE_NUM(LANE_NUM), .FEAT_W(FEAT_W),
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] d3(input int c0l0, input int c0l1, input int c1l0,
                                       input int c1l1, input int c2l0, input int c2l1);
        return {8'(c2l1), 8'(c2l0), 8'(c1l1), 8'(c1l0), 8'(c0l1), 8'(c0l0)};
    endfunction

    function automatic logic [14:0] a3(input int a0, input int a1, input int a2);
        return {5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [15:0] od(input int c, input int l);
        return bus.out_data[(c*LANE_NUM+l)*ACC_W +: ACC_W];
    endfunction

    function automatic logic [7:0] oc(input int c);
        return bus.out_cnt[c*CNT_W +: CNT_W];
    endfunction

    function automatic logic [4:0] oa(input int c);
        return bus.out_addr[c*ADDR_W +: ADDR_W];
    endfunction

    // One valid beat: driven on the falling edge, outputs settle 1 ns after the accepting edge.
    task automatic send(input logic [2:0] en, input logic [2:0] op, input logic [2:0] tag,
                        input logic [14:0] addr, input logic [47:0] data);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_en    = en;
        bus.in_op    = op;
        bus.in_tag   = tag;
        bus.in_addr  = addr;
        bus.in_data  = data;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_en    = '0;
        bus.in_tag   = '0;
    endtask

    task automatic drain();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_en = '0; bus.in_op = '0; bus.in_tag = '0;
        bus.in_addr = '0; bus.in_data = '0; bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 3'b000) begin failures++; $display("FAIL reset_out_valid got=%b exp=000", bus.out_valid); end
        checks++; if (bus.busy !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", bus.busy); end
        checks++; if (bus.err_op !== 3'b000) begin failures++; $display("FAIL reset_err_op got=%b exp=000", bus.err_op); end
        checks++; if (bus.out_data !== '0 || bus.out_cnt !== '0 || bus.out_addr !== '0) begin
            failures++; $display("FAIL reset_outputs data=%h cnt=%h addr=%h exp=0", bus.out_data, bus.out_cnt, bus.out_addr); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add3();
        send(3'b001, 3'b000, 3'b000, a3(7, 0, 0), d3(5, 1, 0, 0, 0, 0));
        checks++; if (bus.busy !== 3'b001 || bus.out_valid !== 3'b000 || oc(0) !== 8'd1) begin
            failures++; $display("FAIL add_first busy=%b valid=%b cnt=%0d exp busy=001 valid=000 cnt=1", bus.busy, bus.out_valid, oc(0)); end
        send(3'b001, 3'b000, 3'b000, a3(9, 0, 0), d3(-3, 2, 0, 0, 0, 0));
        checks++; if (bus.out_valid !== 3'b000) begin failures++; $display("FAIL add_mid_valid got=%b exp=000", bus.out_valid); end
        send(3'b001, 3'b000, 3'b001, a3(9, 0, 0), d3(10, -4, 0, 0, 0, 0));
        checks++; if (bus.out_valid !== 3'b001 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL add_done valid=%b ready=%b exp valid=001 ready=0", bus.out_valid, bus.in_ready); end
        checks++; if (od(0, 0) !== 16'd12 || od(0, 1) !== 16'hFFFF) begin
            failures++; $display("FAIL add_data l0=%h l1=%h exp l0=000c l1=ffff", od(0, 0), od(0, 1)); end
        checks++; if (oc(0) !== 8'd3 || oa(0) !== 5'd7) begin
            failures++; $display("FAIL add_cnt_addr cnt=%0d addr=%0d exp cnt=3 addr=7", oc(0), oa(0)); end
        checks++; if (bus.err_op !== 3'b000) begin failures++; $display("FAIL add_err_op got=%b exp=000", bus.err_op); end
        drain();
        checks++; if (bus.out_valid !== 3'b000 || bus.busy !== 3'b000 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL add_drain valid=%b busy=%b ready=%b exp 000/000/1", bus.out_valid, bus.busy, bus.in_ready); end
        checks++; if (od(0, 0) !== 16'd12 || oc(0) !== 8'd3) begin
            failures++; $display("FAIL add_retain l0=%h cnt=%0d exp l0=000c cnt=3", od(0, 0), oc(0)); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 300; k++) begin
            send(3'b001, 3'b000, (k == 299) ? 3'b001 : 3'b000, a3(4, 0, 0), d3(127, -128, 0, 0, 0, 0));
        end
        checks++; if (bus.out_valid !== 3'b001) begin failures++; $display("FAIL sat_valid got=%b exp=001", bus.out_valid); end
        checks++; if (od(0, 0) !== 16'h7FFF || od(0, 1) !== 16'h8000) begin
            failures++; $display("FAIL sat_data l0=%h l1=%h exp l0=7fff l1=8000", od(0, 0), od(0, 1)); end
        checks++; if (oc(0) !== 8'd255) begin failures++; $display("FAIL sat_cnt got=%0d exp=255", oc(0)); end
        drain();
    endtask

    task automatic test_max_flip();
        send(3'b001, 3'b001, 3'b000, a3(2, 0, 0), d3(-8, 3, 0, 0, 0, 0));
        checks++; if (bus.err_op !== 3'b000) begin failures++; $display("FAIL max_err_early got=%b exp=000", bus.err_op); end
        send(3'b001, 3'b000, 3'b000, a3(2, 0, 0), d3(-2, -7, 0, 0, 0, 0));
        checks++; if (bus.err_op !== 3'b001) begin failures++; $display("FAIL max_err_set got=%b exp=001", bus.err_op); end
        send(3'b001, 3'b001, 3'b001, a3(2, 0, 0), d3(-5, 100, 0, 0, 0, 0));
        checks++; if (od(0, 0) !== 16'hFFFE || od(0, 1) !== 16'd100 || oc(0) !== 8'd3) begin
            failures++; $display("FAIL max_data l0=%h l1=%h cnt=%0d exp l0=fffe l1=0064 cnt=3", od(0, 0), od(0, 1), oc(0)); end
        drain();
        checks++; if (bus.err_op !== 3'b001 || bus.out_valid !== 3'b000) begin
            failures++; $display("FAIL max_err_sticky err=%b valid=%b exp err=001 valid=000", bus.err_op, bus.out_valid); end
    endtask

    task automatic test_back_pressure();
        send(3'b010, 3'b000, 3'b010, a3(0, 3, 0), d3(0, 0, 20, -20, 0, 0));
        checks++; if (bus.out_valid !== 3'b010 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_done valid=%b ready=%b exp valid=010 ready=0", bus.out_valid, bus.in_ready); end
        for (int k = 0; k < 4; k++) begin
            send(3'b111, 3'b000, 3'b000, a3(1, 1, 1), d3(1, 1, 1, 1, 1, 1));
            checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 3'b010 || od(1, 0) !== 16'd20 || od(1, 1) !== 16'hFFEC || oc(1) !== 8'd1) begin
                failures++; $display("FAIL bp_stall cyc=%0d ready=%b busy=%b l0=%h l1=%h cnt=%0d exp ready=0 busy=010 l0=0014 l1=ffec cnt=1",
                                     k, bus.in_ready, bus.busy, od(1, 0), od(1, 1), oc(1)); end
        end
        drain();
        checks++; if (bus.out_valid !== 3'b000 || bus.in_ready !== 1'b1 || od(1, 0) !== 16'd20) begin
            failures++; $display("FAIL bp_release valid=%b ready=%b l0=%h exp valid=000 ready=1 l0=0014", bus.out_valid, bus.in_ready, od(1, 0)); end
    endtask

    task automatic test_mixed_enables();
        send(3'b101, 3'b000, 3'b111, a3(1, 2, 3), d3(4, 5, 6, 7, -9, 1));
        checks++; if (bus.out_valid !== 3'b101 || bus.busy !== 3'b101) begin
            failures++; $display("FAIL mix_valid valid=%b busy=%b exp 101/101", bus.out_valid, bus.busy); end
        checks++; if (oc(0) !== 8'd1 || oc(2) !== 8'd1 || oc(1) !== 8'd1 || od(1, 0) !== 16'd20) begin
            failures++; $display("FAIL mix_cnt c0=%0d c1=%0d c2=%0d c1l0=%h exp 1/1/1 c1l0=0014", oc(0), oc(1), oc(2), od(1, 0)); end
        checks++; if (od(0, 0) !== 16'd4 || od(2, 0) !== 16'hFFF7 || oa(2) !== 5'd3 || oa(0) !== 5'd1) begin
            failures++; $display("FAIL mix_data c0l0=%h c2l0=%h a0=%0d a2=%0d exp 0004 fff7 1 3", od(0, 0), od(2, 0), oa(0), oa(2)); end
        drain();
        checks++; if (bus.out_valid !== 3'b000 || bus.busy !== 3'b000) begin
            failures++; $display("FAIL mix_drain valid=%b busy=%b exp 000/000", bus.out_valid, bus.busy); end
    endtask

    task automatic test_reset_midstream();
        send(3'b001, 3'b000, 3'b000, a3(6, 0, 0), d3(40, 0, 0, 0, 0, 0));
        checks++; if (od(0, 0) !== 16'd40 || bus.busy !== 3'b001) begin
            failures++; $display("FAIL mrst_pre l0=%h busy=%b exp 0028/001", od(0, 0), bus.busy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 3'b000 || bus.out_data !== '0 || bus.out_cnt !== '0 || bus.err_op !== 3'b000 || bus.out_addr !== '0) begin
            failures++; $display("FAIL mrst_async busy=%b data=%h cnt=%h err=%b addr=%h exp all 0",
                                 bus.busy, bus.out_data, bus.out_cnt, bus.err_op, bus.out_addr); end
        @(negedge clk);
        rst = 1'b1;
        send(3'b001, 3'b000, 3'b001, a3(5, 0, 0), d3(5, 0, 0, 0, 0, 0));
        checks++; if (bus.out_valid !== 3'b001 || od(0, 0) !== 16'd5 || oc(0) !== 8'd1 || oa(0) !== 5'd5) begin
            failures++; $display("FAIL mrst_first valid=%b l0=%h cnt=%0d addr=%0d exp 001 0005 1 5", bus.out_valid, od(0, 0), oc(0), oa(0)); end
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add3();
        test_saturation();
        test_max_flip();
        test_back_pressure();
        test_mixed_enables();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simd_agg_array.md
Name: simd_agg_array

Overview:
- Parametrised, stateful successor of the SIMD array: SIMD_NUM independent aggregation cores, each with LANE_NUM lanes.
- Each core accumulates a stream of neighbour feature vectors (add or max) until a tag marks the last element, then presents the result for write-back.
- Sits between the instruction/feature fetch path (upstream) and the result buffer (downstream).
- One beat carries one vector for every enabled core.

Parameters:
SIMD_NUM, 64, number of aggregation cores
LANE_NUM, 32, lanes per core
FEAT_W, 8, input feature width (signed two's complement)
ACC_W, 16, accumulator/output width per lane; must be >= FEAT_W
ADDR_W, 5, destination buffer address width per core
CNT_W, 8, per-core element counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  array can accept a beat
in_en  in  SIMD_NUM  per-core beat enable; disabled cores ignore the beat
in_op  in  SIMD_NUM  per-core opcode: 0 = ADD, 1 = MAX
in_tag  in  SIMD_NUM  per-core last-element flag
in_addr  in  SIMD_NUM*ADDR_W  per-core destination address
in_data  in  SIMD_NUM*LANE_NUM*FEAT_W  feature vectors; core i occupies slice i, lane j within it
out_valid  out  SIMD_NUM  per-core result valid
out_ready  in  1  downstream drains all valid results
out_addr  out  SIMD_NUM*ADDR_W  latched destination address per core
out_data  out  SIMD_NUM*LANE_NUM*ACC_W  aggregated vectors
out_cnt  out  SIMD_NUM*CNT_W  number of elements aggregated per core
busy  out  SIMD_NUM  core holds a partial (ACC) or finished (DONE) aggregation
err_op  out  SIMD_NUM  sticky: opcode changed mid-aggregation

Behaviour:
- Reset (rst low, async): all cores go to IDLE. out_valid, busy, err_op, out_data, out_addr and out_cnt are all zero.
- Accept condition: accept = in_valid & in_ready.
- in_ready = 1 iff no core is in DONE. This is a global stall while any result is undrained. in_ready must not depend on in_valid.
- Per-core FSM:
  - IDLE:
    - accept & en: load acc[j] = sext(in_data lane j); latch op and addr; cnt = 1.
    - tag = 1 -> DONE, else -> ACC.
  - ACC:
    - accept & en: acc[j] = f(acc[j], sext(lane j)) using the latched op; cnt += 1, saturating at 2^CNT_W-1.
    - If in_op differs from the latched op: set err_op, ignore in_op, continue with the latched op.
    - tag = 1 -> DONE.
    - in_addr is ignored in ACC.
  - DONE:
    - out_valid = 1. out_data, out_addr and out_cnt are stable.
    - out_ready = 1 -> IDLE: out_valid drops next cycle, busy clears, out_data/out_cnt retain their value.
- Arithmetic:
  - ADD is signed saturating add to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - MAX is signed maximum.
  - Lanes are independent.
- Latency: a tag beat accepted at edge N gives out_valid high after edge N. One-element aggregations (tag on the first beat) follow the same timing.
- out_ready with no core in DONE has no effect.
- A beat with in_en = 0 for a core leaves that core unchanged, including its counter.
- An accept with all in_en = 0 is legal and has no effect.
- Drain and accept cannot coincide: in_ready is low whenever any core is DONE.
- Mid-operation reset discards all partial results immediately. err_op is cleared only by reset.

Decomposition:
- Package simd_agg_pkg: opcode constants (OP_ADD = 0, OP_MAX = 1), core state enum (IDLE, ACC, DONE), saturating-add and sign-extend functions.
- Sub-module simd_agg_core: one core (FSM, LANE_NUM accumulators, counter, address/op latch). It is instantiated SIMD_NUM times in a generate loop.
- The top level only slices buses, forms in_ready as the NOR of all done flags, and fans out out_ready.

Test Plan:
- Reset mid-stream: core 0 in ACC with acc = 40, assert rst low -> outputs immediately zero, busy[0] = 0; next beat treated as a first element.
- ADD, 3 elements, core 0 lane 0, values 5, -3, 10 (tag on third) -> out_valid[0] one cycle after the third accept; out_data lane 0 = 12, out_cnt = 3, out_addr = address from first beat (7), even though later beats carry 9.
- Saturation: ADD with ACC_W = 16, FEAT_W = 8, 300 beats of +127 -> lane = 32767, cnt saturates at 255.
- MAX with op flip: op = 1 with values -8, -2, -5; second beat carries op = 0 -> result -2, err_op[0] = 1 and remains set after drain.
- Back-pressure: core 1 DONE with out_ready = 0 for 4 cycles -> in_ready = 0, in_valid beats not accepted, out_data stable; out_ready = 1 -> out_valid[1] drops and in_ready rises next cycle.
- Mixed enables: cores 0 and 2 enabled, core 1 disabled, single tag beat -> out_valid = 3'b101, core 1 busy = 0, out_cnt = 1 for cores 0 and 2.
